// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: digit geometry,
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ceil(log2(value)); clog2(BIN_W+1) bits are enough to hold BIN_W.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of double-dabble: a digit of 5 or more
// gets 3 added so the following left shift carries into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // 4-bit add with no carry out; inputs above 9 never occur in a valid accumulator.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds bin steady while in_valid is high; in_ready is
// high only in IDLE. out_valid is high only in DONE, and bcd/blank/overflow
// hold their values until the edge where out_ready is seen high. Both
// in_ready and out_valid decode the state register alone, so there is no
// combinational path from in_valid or out_ready.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIN_W-1:0]            bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]           blank,
  output logic                        overflow
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(BIN_W + 1);

  state_t             state;
  state_t             state_next;
  logic [BIN_W-1:0]   bin_sr;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               ovf_sticky;
  logic               ovf_next;
  logic [CNT_W-1:0]   cnt;
  logic               last_shift;
  logic [DIGITS-1:0]  blank_next;
  logic               zero_run;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The accumulator value after this cycle's shift, and the bit leaving its top.
  assign acc_shift  = {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};
  assign ovf_next   = ovf_sticky | acc_adj[ACC_W-1];
  assign last_shift = (cnt == CNT_W'(1));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Leading-zero mask of the final accumulator; units digit always shown.
  always_comb begin
    zero_run   = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_next[i] = zero_run;
    end
    blank_next[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, count shifts, wait for the consumer in DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid)   state_next = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_next = ST_DONE;
      ST_DONE:  if (out_ready)  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Datapath: load on acceptance, shift while converting, publish results on the final shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr     <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
      bcd        <= '0;
      blank      <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            bin_sr     <= bin;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
          end
        end
        ST_SHIFT: begin
          acc        <= acc_shift;
          bin_sr     <= {bin_sr[BIN_W-2:0], 1'b0};
          ovf_sticky <= ovf_next;
          cnt        <= cnt - CNT_W'(1);
          if (last_shift) begin
            overflow <= ovf_next;
            if (ovf_next) begin
              bcd   <= {DIGITS{BCD_NINE}};
              blank <= '0;
            end else begin
              bcd   <= acc_shift;
              blank <= blank_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and sweep bench for bin2bcd_seq across three parameterisations:
// A = 16-bit/5 digits, B = 8-bit/2 digits, C = 8-bit/3 digits.
module tb_bin2bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1, ovf_a;
  logic [15:0] bin_a = '0;
  logic [19:0] bcd_a;
  logic [4:0]  blank_a;

  logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, ovf_b;
  logic [7:0]  bin_b = '0;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  logic        in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1, ovf_c;
  logic [7:0]  bin_c = '0;
  logic [11:0] bcd_c;
  logic [2:0]  blank_c;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .bin(bin_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .bcd(bcd_a), .blank(blank_a),
    .overflow(ovf_a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .bin(bin_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .bcd(bcd_b), .blank(blank_b),
    .overflow(ovf_b)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .bin(bin_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .bcd(bcd_c), .blank(blank_c),
    .overflow(ovf_c)
  );

  // ---------------- scoreboard ----------------
  // Entries are {overflow, blank, bcd} packed low-aligned for the instance in use.
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int digits_of(input int id);
    return (id == 0) ? 5 : (id == 1) ? 2 : 3;
  endfunction

  function automatic int binw_of(input int id);
    return (id == 0) ? 16 : 8;
  endfunction

  // Reference model: decimal digits by division, blanking by significant-digit count.
  function automatic logic [31:0] model(input int id, input int v);
    int d, lim, t, n;
    logic [31:0] b, bl, ov;
    d = digits_of(id);
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    b = '0; bl = '0; ov = '0;
    if (v >= lim) begin
      ov = 32'd1;
      for (int i = 0; i < d; i++) b = b | (32'd9 << (4 * i));
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        b = b | (32'(t % 10) << (4 * i));
        t = t / 10;
      end
      t = v; n = 1;
      while (t >= 10) begin t = t / 10; n++; end
      for (int i = n; i < d; i++) bl = bl | (32'd1 << i);
    end
    return b | (bl << (4 * d)) | (ov << (5 * d));
  endfunction

  function automatic logic [31:0] get_obs(input int id);
    case (id)
      0:       return 32'({ovf_a, blank_a, bcd_a});
      1:       return 32'({ovf_b, blank_b, bcd_b});
      default: return 32'({ovf_c, blank_c, bcd_c});
    endcase
  endfunction

  function automatic logic [31:0] out_valid_of(input int id);
    case (id)
      0:       return 32'(out_valid_a);
      1:       return 32'(out_valid_b);
      default: return 32'(out_valid_c);
    endcase
  endfunction

  function automatic logic [31:0] in_ready_of(input int id);
    case (id)
      0:       return 32'(in_ready_a);
      1:       return 32'(in_ready_b);
      default: return 32'(in_ready_c);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input int v, input logic valid);
    case (id)
      0:       begin bin_a = 16'(v); in_valid_a = valid; end
      1:       begin bin_b = 8'(v);  in_valid_b = valid; end
      default: begin bin_c = 8'(v);  in_valid_c = valid; end
    endcase
  endtask

  // Present one value for a single edge; the DUT must be IDLE so it is accepted.
  task automatic start(input int id, input int v, input bit push);
    @(negedge clk);
    drive(id, v, 1'b1);
    if (push) exp_q.push_back(model(id, v));
    @(posedge clk);
    #1;
    drive(id, v, 1'b0);
    check("accepted_in_ready_low", in_ready_of(id), 32'd0);
  endtask

  // Wait (bounded) for out_valid, check latency, then pop and compare the result.
  task automatic finish_conv(input int id, input string tag);
    int lat;
    logic [31:0] exp;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_of(id) == 32'd1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(binw_of(id)));
    if (lat != 0 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check(tag, get_obs(id), exp);
    end
  endtask

  // With out_ready high, the result is consumed at the next edge.
  task automatic consume(input int id, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_consumed_valid"}, out_valid_of(id), 32'd0);
    check({tag, "_consumed_ready"}, in_ready_of(id), 32'd1);
  endtask

  task automatic convert(input int id, input int v, input string tag);
    start(id, v, 1'b1);
    finish_conv(id, tag);
    consume(id, tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state.
    #1;
    check("reset_out_valid", 32'(out_valid_a), 32'd0);
    check("reset_in_ready", 32'(in_ready_a), 32'd1);
    check("reset_outputs", get_obs(0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full-scale 16-bit and small values with blanking.
    convert(0, 65535, "a_65535");
    convert(0, 0,     "a_zero");
    convert(0, 407,   "a_407");
    convert(0, 9,     "a_9");
    convert(0, 10000, "a_10000");

    // Overflow saturation on the 2-digit instance, then largest in-range value.
    convert(1, 200, "b_200");
    convert(1, 99,  "b_99");
    convert(1, 100, "b_100");
    convert(1, 255, "b_255");
    convert(1, 5,   "b_5");

    // Backpressure: result held while out_ready is low, in_valid pulses ignored.
    out_ready_a = 1'b0;
    start(0, 31337, 1'b1);
    finish_conv(0, "a_bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, int'($urandom_range(0, 65535)), 1'b1);
      @(posedge clk);
      #1;
      check("bp_hold_result", get_obs(0), model(0, 31337));
      check("bp_in_ready", in_ready_of(0), 32'd0);
      check("bp_out_valid", out_valid_of(0), 32'd1);
    end
    @(negedge clk);
    drive(0, 0, 1'b0);
    out_ready_a = 1'b1;
    consume(0, "a_bp");
    convert(0, 4321, "a_after_bp");

    // Asynchronous reset in the middle of a conversion.
    start(0, 50000, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", out_valid_of(0), 32'd0);
    check("midreset_in_ready", in_ready_of(0), 32'd1);
    check("midreset_outputs", get_obs(0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    convert(0, 1234, "a_1234");

    // Random 16-bit values.
    for (int i = 0; i < 8; i++) begin
      convert(0, int'($urandom_range(0, 65535)), "a_rand");
    end

    // Exhaustive 8-bit sweep on the 3-digit instance.
    for (int v = 0; v < 256; v++) begin
      convert(2, v, "c_sweep");
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one shift per clock. It generalises the team's fixed 8-bit combinational converter to any input width and digit count. It adds a valid/ready handshake on both sides, overflow saturation and a leading-zero blanking mask. It sits between arithmetic/counter blocks and the seven-segment display drivers.

## Interface
- BIN_W, 16, binary input width (≥ 4)
- DIGITS, 5, number of BCD output digits (≥ 1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  bin is valid this cycle
- in_ready  out  1  block can accept bin (high only in IDLE)
- bin  in  BIN_W  unsigned binary value
- out_valid  out  1  bcd/blank/overflow valid
- out_ready  in  1  downstream accepts result
- bcd  out  4*DIGITS  packed BCD; digit i at bits [4i+3:4i], digit 0 = units
- blank  out  DIGITS  bit i = 1 when digit i is a leading zero
- overflow  out  1  bin ≥ 10^DIGITS; bcd saturated

## Operation
- Reset (async, any state): state = IDLE; in_ready = 1; out_valid = 0; bcd = 0; blank = 0; overflow = 0; shift counter = 0.
- States:
  - IDLE: in_ready = 1. On in_valid, latch bin into the binary shift register, clear the BCD accumulator and the overflow flag, set counter = BIN_W, and go to SHIFT.
  - SHIFT: each cycle, every digit of the accumulator that is ≥ 5 gets +3 (4-bit, no carry between digits). Then the concatenation {accumulator, binary} shifts left by 1. If the bit shifted out of the top digit is 1, the sticky overflow flag is set. The counter decrements; when it reaches 0 after this shift, go to DONE.
  - DONE: out_valid = 1; in_ready = 0; outputs stable. On out_ready, go to IDLE.
- Output registers load on the SHIFT→DONE transition:
  - If overflow: bcd = all digits 9, blank = 0.
  - Otherwise: bcd = accumulator; blank bit i = 1 iff digits DIGITS-1..i are all zero, with bit 0 forced to 0, so value 0 shows a single "0".
- in_valid is ignored outside IDLE; bin is sampled only at acceptance.
- In DONE, outputs stay unchanged while out_ready = 0, for an unbounded time.
- Reset asserted mid-conversion discards the conversion; no partial result is ever presented.
- Width rule: the accumulator is exactly 4*DIGITS bits. With DIGITS ≥ ceil(BIN_W·log10 2), overflow can never occur.

## Timing
- Acceptance at rising edge k (IDLE, in_valid = 1). Shifts occur at edges k+1 … k+BIN_W. out_valid rises at edge k+BIN_W.
- Latency from acceptance to out_valid = BIN_W cycles.
- Consumption at edge m (DONE, out_ready = 1): out_valid = 0 and in_ready = 1 from edge m+1.
- Minimum issue interval is BIN_W+2 cycles (out_ready tied high). No back-to-back acceptance in the DONE cycle.
- in_ready and out_valid are pure decodes of the state register, with no combinational path from in_valid or out_ready.

## Structure
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4 and BCD_NINE = 4'd9
  - state encoding constants ST_IDLE, ST_SHIFT, ST_DONE
  - function clog2 used to size the counter as clog2(BIN_W+1)
- Sub-module bcd_digit_adj: combinational 4-bit "if ≥ 5 add 3", instantiated DIGITS times via generate.
- Everything else (state register, counter, shift registers, output registers, blank logic) lives in bin2bcd_seq.

## Test plan
- Defaults, bin = 16'd65535, out_ready = 1 → out_valid exactly 16 cycles after acceptance; bcd = 20'h65535, blank = 5'b00000, overflow = 0.
- Defaults, bin = 0 → bcd = 20'h00000, blank = 5'b11110. Then bin = 16'd407 → bcd = 20'h00407, blank = 5'b11000.
- BIN_W = 8, DIGITS = 2, bin = 8'd200 → overflow = 1, bcd = 8'h99, blank = 2'b00. Then bin = 8'd99 → overflow = 0, bcd = 8'h99.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → bcd stable, in_ready = 0, in_valid pulses with other values ignored; next accepted value converts correctly.
- Reset at cycle 5 of a SHIFT phase → all outputs at reset values immediately (async). Next conversion of 16'd1234 → bcd = 20'h01234.
- Exhaustive sweep, BIN_W = 8, DIGITS = 3, all 256 inputs → bcd matches a reference model and overflow = 0 throughout.
